// File: rtl/ofm_write_scheduler_pkg.sv
// rtl/ofm_write_scheduler_pkg.sv - FSM encoding and derived geometry constants for the OFM write scheduler
package ofm_write_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TILE = 3'd1,
        WRITE     = 3'd2,
        UPDATE    = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int DEF_SYSTOLIC_SIZE = 16;
    localparam int DEF_OFM_SIZE      = 32;
    localparam int DEF_NUM_FILTER    = 32;
    localparam int DEF_ADDR_WIDTH    = 22;

    // Distance between two output channels in OFM memory
    function automatic int ch_stride_f(input int ofm_size);
        return ofm_size * ofm_size;
    endfunction

    // Tiles needed to cover one channel plane
    function automatic int tiles_f(input int ofm_size, input int systolic_size);
        return (ofm_size * ofm_size) / systolic_size;
    endfunction

    // Channel groups needed to cover all filters
    function automatic int groups_f(input int num_filter, input int systolic_size);
        return num_filter / systolic_size;
    endfunction

    localparam int CH_STRIDE = ch_stride_f(DEF_OFM_SIZE);
    localparam int TILES     = tiles_f(DEF_OFM_SIZE, DEF_SYSTOLIC_SIZE);
    localparam int GROUPS    = groups_f(DEF_NUM_FILTER, DEF_SYSTOLIC_SIZE);

endpackage

// File: rtl/ofm_write_scheduler_if.sv
// rtl/ofm_write_scheduler_if.sv - scheduler control/write bus; wr_stall exists only under OFM_WR_STALL_EN
interface ofm_write_scheduler_if #(
    parameter int ADDR_WIDTH = 22
) ();
    logic                  start;
    logic                  tile_valid;
    logic                  tile_ready;
    logic [ADDR_WIDTH-1:0] ofm_addr;
    logic                  ofm_wr_en;
    logic [4:0]            ch_sel;
    logic                  busy;
    logic                  done;
`ifdef OFM_WR_STALL_EN
    logic                  wr_stall;
`endif

    modport master (
`ifdef OFM_WR_STALL_EN
        input  wr_stall,
`endif
        input  start,
        input  tile_valid,
        output tile_ready,
        output ofm_addr,
        output ofm_wr_en,
        output ch_sel,
        output busy,
        output done
    );

    modport slave (
`ifdef OFM_WR_STALL_EN
        output wr_stall,
`endif
        output start,
        output tile_valid,
        input  tile_ready,
        input  ofm_addr,
        input  ofm_wr_en,
        input  ch_sel,
        input  busy,
        input  done
    );
endinterface

// File: rtl/ofm_tile_counter.sv
// rtl/ofm_tile_counter.sv - tile/group position and tile base address within the OFM
module ofm_tile_counter
    import ofm_write_scheduler_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int OFM_SIZE      = DEF_OFM_SIZE,
    parameter int NUM_FILTER    = DEF_NUM_FILTER,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  last_tile,
    output logic                  last_group
);
    localparam int N_TILES  = tiles_f(OFM_SIZE, SYSTOLIC_SIZE);
    localparam int N_GROUPS = groups_f(NUM_FILTER, SYSTOLIC_SIZE);
    localparam int TW = (N_TILES  > 1) ? $clog2(N_TILES)  : 1;
    localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [ADDR_WIDTH-1:0] TILE_STEP  = ADDR_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [ADDR_WIDTH-1:0] GROUP_STEP = ADDR_WIDTH'(SYSTOLIC_SIZE * ch_stride_f(OFM_SIZE));

    logic [TW-1:0]         tile_cnt;
    logic [GW-1:0]         group_cnt;
    logic [ADDR_WIDTH-1:0] group_base;

    assign last_tile  = (tile_cnt  == TW'(N_TILES - 1));
    assign last_group = (group_cnt == GW'(N_GROUPS - 1));

    // Step to the next tile, rolling into the next channel group at the plane end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt   <= '0;
            group_cnt  <= '0;
            group_base <= '0;
            base_addr  <= '0;
        end else if (clear) begin
            tile_cnt   <= '0;
            group_cnt  <= '0;
            group_base <= '0;
            base_addr  <= '0;
        end else if (advance) begin
            if (!last_tile) begin
                tile_cnt  <= tile_cnt + TW'(1);
                base_addr <= base_addr + TILE_STEP;
            end else if (!last_group) begin
                tile_cnt   <= '0;
                group_cnt  <= group_cnt + GW'(1);
                group_base <= group_base + GROUP_STEP;
                base_addr  <= group_base + GROUP_STEP;
            end
        end
    end
endmodule

// File: rtl/ofm_write_scheduler.sv
// rtl/ofm_write_scheduler.sv - drains systolic tiles channel by channel into OFM memory; optional OFM_WR_STALL_EN
module ofm_write_scheduler
    import ofm_write_scheduler_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int OFM_SIZE      = DEF_OFM_SIZE,
    parameter int NUM_FILTER    = DEF_NUM_FILTER,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ofm_write_scheduler_if.master  bus
);
    localparam int KW = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] CH_STEP = ADDR_WIDTH'(ch_stride_f(OFM_SIZE));

    state_t                state, state_nxt;
    logic [KW-1:0]         k;
    logic [ADDR_WIDTH-1:0] addr_acc;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  last_tile, last_group;
    logic                  stall, k_last, ctr_clear, ctr_advance;

`ifdef OFM_WR_STALL_EN
    assign stall = bus.wr_stall;
`else
    assign stall = 1'b0;
`endif

    assign k_last      = (k == KW'(SYSTOLIC_SIZE - 1));
    assign ctr_clear   = (state == IDLE) && bus.start;
    assign ctr_advance = (state == UPDATE);

    ofm_tile_counter #(
        .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
        .OFM_SIZE      (OFM_SIZE),
        .NUM_FILTER    (NUM_FILTER),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_tile_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (ctr_clear),
        .advance    (ctr_advance),
        .base_addr  (base_addr),
        .last_tile  (last_tile),
        .last_group (last_group)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; tile_valid only matters while waiting, start only while idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.start) state_nxt = WAIT_TILE;
            WAIT_TILE: if (bus.tile_valid) state_nxt = WRITE;
            WRITE:     if (!stall && k_last) state_nxt = UPDATE;
            UPDATE:    state_nxt = (last_tile && last_group) ? DONE : WAIT_TILE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Channel index and running channel address; preloaded with the tile base outside WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            addr_acc <= '0;
        end else if (state != WRITE) begin
            k        <= '0;
            addr_acc <= base_addr;
        end else if (!stall) begin
            k        <= k_last ? '0 : k + KW'(1);
            addr_acc <= addr_acc + CH_STEP;
        end
    end

    // Output decode from registered state and datapath
    always_comb begin
        bus.ofm_wr_en  = (state == WRITE) && !stall;
        bus.ch_sel     = (state == WRITE) ? 5'(k) : 5'd0;
        bus.ofm_addr   = (state == WRITE) ? addr_acc : base_addr;
        bus.tile_ready = (state == UPDATE);
        bus.busy       = (state == WAIT_TILE) || (state == WRITE) || (state == UPDATE);
        bus.done       = (state == DONE);
    end
endmodule

// File: doc/ofm_write_scheduler.md
OFM_WRITE_SCHEDULER -- requirements
Module: ofm_write_scheduler

Interface
REQ-001 Parameter SYSTOLIC_SIZE, default 16: output channels per tile and pixels per tile row segment.
REQ-002 Parameter OFM_SIZE, default 32: OFM width and height, in pixels.
REQ-003 Parameter NUM_FILTER, default 32: total output channels; SHALL be a multiple of SYSTOLIC_SIZE.
REQ-004 Parameter ADDR_WIDTH, default 22: OFM address width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse that begins a full layer drain; ignored unless IDLE.
REQ-008 tile_valid  input  1  systolic array has a finished tile ready to drain.
REQ-009 tile_ready  output  1  one-cycle pulse when the tile has been fully drained; array may release it.
REQ-010 ofm_addr  output  ADDR_WIDTH  write address for the current channel.
REQ-011 ofm_wr_en  output  1  write strobe, valid with ofm_addr.
REQ-012 ch_sel  output  5  index of the array output channel driven to memory.
REQ-013 busy  output  1  high from start acceptance until done.
REQ-014 done  output  1  one-cycle pulse after the last tile of the last channel group.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_TILE, WRITE, UPDATE and DONE.
REQ-016 IDLE -> WAIT_TILE on start; base_addr, tile_cnt and group_cnt SHALL clear on that edge.
REQ-017 WAIT_TILE -> WRITE on the first cycle tile_valid=1.
REQ-018 WRITE SHALL last exactly SYSTOLIC_SIZE cycles, with ch_sel=k in cycle k (k=0..SYSTOLIC_SIZE-1).
REQ-019 In each WRITE cycle: ofm_wr_en=1 and ofm_addr = base_addr + k*OFM_SIZE*OFM_SIZE (registered, same cycle as ch_sel).
REQ-020 WRITE -> UPDATE after k=SYSTOLIC_SIZE-1; tile_ready SHALL pulse in the UPDATE cycle.
REQ-021 UPDATE, tile_cnt < TILES-1 (TILES = OFM_SIZE*OFM_SIZE/SYSTOLIC_SIZE): tile_cnt+1, base_addr += SYSTOLIC_SIZE, -> WAIT_TILE.
REQ-022 UPDATE, last tile, group_cnt < NUM_FILTER/SYSTOLIC_SIZE-1: tile_cnt=0, group_cnt+1, base_addr = (group_cnt+1)*SYSTOLIC_SIZE*OFM_SIZE*OFM_SIZE, -> WAIT_TILE.
REQ-023 UPDATE, last tile of last group: -> DONE; done pulses for one cycle; -> IDLE next cycle.
REQ-024 Address arithmetic SHALL be computed at ADDR_WIDTH bits with wrap on overflow; the parameter set SHALL keep the peak address below 2^ADDR_WIDTH.
REQ-025 tile_valid dropping during WRITE SHALL NOT abort or pause the drain; it is sampled only in WAIT_TILE.
REQ-026 start asserted while busy=1 SHALL be ignored, with no counter disturbance.
REQ-027 Outside WRITE: ofm_wr_en=0, ch_sel=0, and ofm_addr holds base_addr.

Reset
REQ-028 On rst_n=0, at any time including mid-WRITE: state=IDLE; ofm_addr, ofm_wr_en, ch_sel, tile_ready, busy, done, base_addr and all counters SHALL be 0 immediately.
REQ-029 After reset release, no write SHALL occur before a new start.

Configuration
REQ-030 Macro OFM_WR_STALL_EN: when defined, an input port wr_stall (1 bit) SHALL exist, and wr_stall=1 during WRITE SHALL freeze k, ofm_addr and ch_sel and force ofm_wr_en=0 until it deasserts.
REQ-031 Without OFM_WR_STALL_EN: no wr_stall port; WRITE SHALL always complete in exactly SYSTOLIC_SIZE cycles.

Structure
REQ-032 A shared package SHALL hold the FSM state encodings and the derived constants TILES, GROUPS and CH_STRIDE (=OFM_SIZE*OFM_SIZE).
REQ-033 One sub-module, ofm_tile_counter, SHALL hold tile_cnt, group_cnt and base_addr, and flag last_tile and last_group; the FSM and output registers SHALL stay in the top module.

Verification (SYSTOLIC_SIZE=16, OFM_SIZE=32, NUM_FILTER=32)
REQ-034 Start, then tile_valid=1 -> 16 writes at addresses 0,1024,...,15360 with ch_sel 0..15; then one tile_ready pulse.
REQ-035 Second tile -> addresses 16,1040,...,15376; tile 63 of group 0 -> base 1008.
REQ-036 First tile of group 1 -> base 16384; the full run gives 128 tile_ready pulses, 2048 writes, then exactly one done pulse with busy falling in the same cycle.
REQ-037 rst_n low during write k=7 of tile 5 -> all outputs 0 that cycle; after a new start, the first address is 0.
REQ-038 start pulsed mid-run, and tile_valid toggled during WRITE -> the address sequence is identical to the uninterrupted run.
REQ-039 With OFM_WR_STALL_EN: wr_stall high for 3 cycles at k=4 -> address 4096 is held, ofm_wr_en=0 for 3 cycles, and the tile takes 19 WRITE cycles.
